// File: rtl/bin2bcd_seq.sv
// Iterative binary-to-BCD converter (shift-and-add-3).
// Saturates to all nines when the value does not fit in DIGITS.
module bin2bcd_seq #(
  parameter int WIDTH  = 14,
  parameter int DIGITS = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [WIDTH-1:0]      bin,
  output logic                  busy,
  output logic                  done,
  output logic [4*DIGITS-1:0]   bcd,
  output logic                  overflow
);

  localparam int BW = 4 * DIGITS;
  localparam int RW = BW + WIDTH;
  localparam int CW = $clog2(WIDTH + 1);

  function automatic logic [31:0] pow10(input int n);
    logic [31:0] p;
    p = 32'd1;
    for (int i = 0; i < n; i++) begin
      p = p * 32'd10;
    end
    return p;
  endfunction

  localparam logic [31:0] LIMIT = pow10(DIGITS) - 32'd1;
  localparam logic [CW-1:0] CNT_INIT = CW'(WIDTH);
  localparam logic [CW-1:0] CNT_LAST = CW'(1);

  typedef enum logic {
    IDLE,
    SHIFT
  } state_t;

  state_t          state;
  state_t          state_nxt;
  logic [RW-1:0]   work;
  logic [RW-1:0]   work_nxt;
  logic [RW-1:0]   adj;
  logic [RW-1:0]   shifted;
  logic [CW-1:0]   cnt;
  logic [CW-1:0]   cnt_nxt;
  logic            ovf_int;
  logic            ovf_nxt;
  logic            busy_nxt;
  logic            done_nxt;
  logic [BW-1:0]   bcd_nxt;
  logic            overflow_nxt;
  logic [31:0]     bin_ext;
  logic [BW-1:0]   nines;

  assign bin_ext = 32'(bin);
  assign nines   = {DIGITS{4'h9}};

  // Add 3 to every BCD nibble >= 5, nibbles independent, then shift.
  always_comb begin
    adj = work;
    for (int i = 0; i < DIGITS; i++) begin
      if (work[WIDTH+4*i +: 4] >= 4'd5) begin
        adj[WIDTH+4*i +: 4] = work[WIDTH+4*i +: 4] + 4'd3;
      end
    end
    shifted = {adj[RW-2:0], 1'b0};
  end

  // Next-state and datapath updates for the two-state controller.
  always_comb begin
    state_nxt    = state;
    work_nxt     = work;
    cnt_nxt      = cnt;
    ovf_nxt      = ovf_int;
    busy_nxt     = busy;
    done_nxt     = 1'b0;
    bcd_nxt      = bcd;
    overflow_nxt = overflow;
    unique case (state)
      IDLE: begin
        if (start) begin
          work_nxt  = {{BW{1'b0}}, bin};
          cnt_nxt   = CNT_INIT;
          ovf_nxt   = bin_ext > LIMIT;
          busy_nxt  = 1'b1;
          state_nxt = SHIFT;
        end
      end
      SHIFT: begin
        work_nxt = shifted;
        cnt_nxt  = cnt - 1'b1;
        if (cnt == CNT_LAST) begin
          bcd_nxt      = ovf_int ? nines : shifted[RW-1 -: BW];
          overflow_nxt = ovf_int;
          done_nxt     = 1'b1;
          busy_nxt     = 1'b0;
          state_nxt    = IDLE;
        end
      end
    endcase
  end

  // State register; reset aborts any conversion in flight.
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      work     <= '0;
      cnt      <= '0;
      ovf_int  <= 1'b0;
      busy     <= 1'b0;
      done     <= 1'b0;
      bcd      <= '0;
      overflow <= 1'b0;
    end else begin
      state    <= state_nxt;
      work     <= work_nxt;
      cnt      <= cnt_nxt;
      ovf_int  <= ovf_nxt;
      busy     <= busy_nxt;
      done     <= done_nxt;
      bcd      <= bcd_nxt;
      overflow <= overflow_nxt;
    end
  end

endmodule

// File: tb/tb_bin2bcd_seq.sv
// Scoreboard bench for bin2bcd_seq: default size plus two small variants.
// Expected results are queued at stimulus time and popped on done.
module tb_bin2bcd_seq;

  typedef struct {
    logic [23:0] b;
    logic        o;
  } exp_t;

  logic        clk;
  logic        rst;
  logic        start0, start3, start2;
  logic [13:0] bin0;
  logic [7:0]  bin8;
  logic        busy0, done0, ovf0;
  logic        busy3, done3, ovf3;
  logic        busy2, done2, ovf2;
  logic [15:0] bcd0;
  logic [11:0] bcd3;
  logic [7:0]  bcd2;

  exp_t q0[$];
  exp_t q3[$];
  exp_t q2[$];

  int checks;
  int errors;

  bin2bcd_seq #(.WIDTH(14), .DIGITS(4)) dut0 (
    .clk(clk), .rst(rst), .start(start0), .bin(bin0),
    .busy(busy0), .done(done0), .bcd(bcd0), .overflow(ovf0)
  );

  bin2bcd_seq #(.WIDTH(8), .DIGITS(3)) dut3 (
    .clk(clk), .rst(rst), .start(start3), .bin(bin8),
    .busy(busy3), .done(done3), .bcd(bcd3), .overflow(ovf3)
  );

  bin2bcd_seq #(.WIDTH(8), .DIGITS(2)) dut2 (
    .clk(clk), .rst(rst), .start(start2), .bin(bin8),
    .busy(busy2), .done(done2), .bcd(bcd2), .overflow(ovf2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic exp_t ref_of(input int v, input int d);
    exp_t e;
    int p;
    int x;
    p = 1;
    x = v;
    e.b = '0;
    for (int i = 0; i < d; i++) p = p * 10;
    e.o = (v >= p);
    for (int i = 0; i < d; i++) begin
      e.b[4*i +: 4] = e.o ? 4'd9 : 4'(x % 10);
      x = x / 10;
    end
    return e;
  endfunction

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp,
               $time);
    end
  endtask

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic mon_one(input string name, input logic [23:0] act,
                         input logic o, input int d, ref exp_t q[$]);
    exp_t e;
    logic ok;
    if (q.size() == 0) begin
      chk({name, "_unexpected_done"}, 32'd1, 32'd0);
    end else begin
      e = q.pop_front();
      chk({name, "_bcd"}, 32'(act), 32'(e.b));
      chk({name, "_ovf"}, 32'(o), 32'(e.o));
      ok = 1'b1;
      for (int i = 0; i < d; i++) begin
        if (act[4*i +: 4] > 4'd9) ok = 1'b0;
      end
      chk({name, "_digits_legal"}, 32'(ok), 32'd1);
    end
  endtask

  task automatic monitor();
    forever begin
      @(negedge clk);
      if (done0) mon_one("d0", 24'(bcd0), ovf0, 4, q0);
      if (done3) mon_one("d3", 24'(bcd3), ovf3, 3, q3);
      if (done2) mon_one("d2", 24'(bcd2), ovf2, 2, q2);
    end
  endtask

  task automatic wait_done0();
    int n;
    n = 0;
    while (!done0 && n < 40) begin
      tick();
      n++;
    end
    if (!done0) chk("d0_done_timeout", 32'd0, 32'd1);
  endtask

  task automatic wait_idle0();
    int n;
    n = 0;
    while (busy0 && n < 40) begin
      tick();
      n++;
    end
    if (busy0) chk("d0_idle_timeout", 32'd1, 32'd0);
  endtask

  task automatic run0(input int v);
    wait_idle0();
    start0 = 1'b1;
    bin0   = 14'(v);
    q0.push_back(ref_of(v, 4));
    tick();
    start0 = 1'b0;
    wait_done0();
  endtask

  task automatic run_small(input bit three, input int v);
    int n;
    bin8 = 8'(v);
    if (three) begin
      start3 = 1'b1;
      q3.push_back(ref_of(v, 3));
    end else begin
      start2 = 1'b1;
      q2.push_back(ref_of(v, 2));
    end
    tick();
    start3 = 1'b0;
    start2 = 1'b0;
    n = 1;
    while (!(three ? done3 : done2) && n < 40) begin
      tick();
      n++;
    end
    // Done is first seen half a cycle after edge accept+8.
    chk(three ? "d3_latency" : "d2_latency", 32'(n), 32'd9);
  endtask

  initial begin
    int lat;
    int nb;
    checks = 0;
    errors = 0;
    rst    = 1'b1;
    start0 = 1'b0;
    start3 = 1'b0;
    start2 = 1'b0;
    bin0   = '0;
    bin8   = '0;
    fork
      monitor();
    join_none
    tick();
    tick();
    chk("rst_busy", 32'(busy0), 32'd0);
    chk("rst_done", 32'(done0), 32'd0);
    chk("rst_bcd", 32'(bcd0), 32'd0);
    chk("rst_ovf", 32'(ovf0), 32'd0);
    rst = 1'b0;
    tick();

    // Latency: busy sampled high 14 times, done seen after edge accept+14.
    start0 = 1'b1;
    bin0   = 14'd1234;
    q0.push_back(ref_of(1234, 4));
    tick();
    start0 = 1'b0;
    nb  = busy0 ? 1 : 0;
    lat = 1;
    while (!done0 && lat < 40) begin
      tick();
      lat++;
      if (busy0) nb++;
    end
    chk("latency", 32'(lat), 32'd15);
    chk("busy_cycles", 32'(nb), 32'd14);
    chk("busy_at_done", 32'(busy0), 32'd0);
    chk("bcd_1234", 32'(bcd0), 32'h1234);
    tick();
    chk("done_one_cycle", 32'(done0), 32'd0);
    chk("bcd_hold", 32'(bcd0), 32'h1234);

    run0(0);
    chk("bcd_0", 32'(bcd0), 32'h0000);
    run0(9999);
    chk("bcd_9999", 32'(bcd0), 32'h9999);
    chk("ovf_9999", 32'(ovf0), 32'd0);
    run0(10000);
    chk("bcd_10000", 32'(bcd0), 32'h9999);
    chk("ovf_10000", 32'(ovf0), 32'd1);
    run0(16383);
    chk("bcd_16383", 32'(bcd0), 32'h9999);
    chk("ovf_16383", 32'(ovf0), 32'd1);
    run0(42);
    chk("bcd_42", 32'(bcd0), 32'h0042);
    chk("ovf_42", 32'(ovf0), 32'd0);

    // Start during a conversion is dropped; start in done cycle is taken.
    wait_idle0();
    start0 = 1'b1;
    bin0   = 14'd500;
    q0.push_back(ref_of(500, 4));
    tick();
    start0 = 1'b0;
    repeat (4) tick();
    start0 = 1'b1;
    bin0   = 14'd777;
    tick();
    start0 = 1'b0;
    wait_done0();
    chk("bcd_500", 32'(bcd0), 32'h0500);
    start0 = 1'b1;
    bin0   = 14'd777;
    q0.push_back(ref_of(777, 4));
    tick();
    start0 = 1'b0;
    chk("b2b_accept_busy", 32'(busy0), 32'd1);
    wait_done0();
    chk("bcd_777", 32'(bcd0), 32'h0777);

    // Start held high: two conversions, bin change mid-shift ignored.
    tick();
    start0 = 1'b1;
    bin0   = 14'd42;
    q0.push_back(ref_of(42, 4));
    q0.push_back(ref_of(9999, 4));
    tick();
    bin0 = 14'd9999;
    wait_done0();
    chk("held_first", 32'(bcd0), 32'h0042);
    tick();
    wait_done0();
    start0 = 1'b0;
    chk("held_second", 32'(bcd0), 32'h9999);
    tick();

    // Reset mid-conversion: no done, bcd cleared.
    wait_idle0();
    start0 = 1'b1;
    bin0   = 14'd1234;
    tick();
    start0 = 1'b0;
    repeat (6) tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("abort_busy", 32'(busy0), 32'd0);
    chk("abort_done", 32'(done0), 32'd0);
    chk("abort_bcd", 32'(bcd0), 32'd0);
    repeat (30) tick();
    chk("abort_bcd_stays", 32'(bcd0), 32'd0);
    run0(8);
    chk("bcd_8", 32'(bcd0), 32'h0008);

    // Sweep against the reference model.
    for (int v = 0; v <= 9999; v += 7) run0(v);
    run0(9999);

    // Small variants.
    run_small(1'b1, 255);
    chk("v3_bcd_255", 32'(bcd3), 32'h255);
    run_small(1'b1, 0);
    run_small(1'b1, 99);
    run_small(1'b0, 99);
    chk("v2_bcd_99", 32'(bcd2), 32'h99);
    chk("v2_ovf_99", 32'(ovf2), 32'd0);
    run_small(1'b0, 100);
    chk("v2_bcd_100", 32'(bcd2), 32'h99);
    chk("v2_ovf_100", 32'(ovf2), 32'd1);
    run_small(1'b0, 7);

    repeat (20) tick();
    chk("q0_drained", 32'(q0.size()), 32'd0);
    chk("q3_drained", 32'(q3.size()), 32'd0);
    chk("q2_drained", 32'(q2.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
